// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract datapath:
// the slice width and the sequencer state encoding.
package addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        NSA_IDLE,
        NSA_RUN,
        NSA_DONE
    } nsa_state_t;

endpackage

// File: rtl/fasrip.sv
// fasrip: 4-bit ripple-carry add/subtract slice.
// With s_op=1 the b operand is inverted, so the caller supplies cin=1
// on the first pass to form the two's complement of b.
module fasrip
    import addsub_pkg::*;
(
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    input  logic                s_op
);

    logic [NIBBLE_W-1:0] b_x;
    logic [NIBBLE_W:0]   c;

    assign b_x  = b ^ {NIBBLE_W{s_op}};
    assign c[0] = cin;

    // One full adder per bit, carry rippling from bit 0 upward.
    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b_x[i] ^ c[i];
        assign c[i+1] = (a[i] & b_x[i]) | (c[i] & (a[i] ^ b_x[i]));
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: WIDTH-bit add/subtract built from one 4-bit slice.
// Operands are latched on start and fed to the slice one nibble per clock,
// LSB first, with the carry chained through carry_r. The result is shifted
// in from the top so it is aligned once the last nibble has been processed.
// Optional feature: define NSA_OVF_EN to produce the signed overflow flag;
// without it ovf is tied low and no MSB capture logic exists.
module nibble_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    nsa_state_t          state;
    logic [WIDTH-1:0]    a_r;
    logic [WIDTH-1:0]    b_r;
    logic                sub_r;
    logic                carry_r;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    result_r;
    logic                cout_r;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_cout;

`ifdef NSA_OVF_EN
    logic [1:0]          msb_r;
    logic                ovf_r;
`endif

    fasrip u_slice (
        .s    (slice_s),
        .cout (slice_cout),
        .a    (a_r[NIBBLE_W-1:0]),
        .b    (b_r[NIBBLE_W-1:0]),
        .cin  (carry_r),
        .s_op (sub_r)
    );

    // Sequencer: accept a request, run one slice pass per nibble, then
    // present the finished result for a single done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= NSA_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            sub_r    <= 1'b0;
            carry_r  <= 1'b0;
            cnt      <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
`ifdef NSA_OVF_EN
            msb_r    <= 2'b00;
            ovf_r    <= 1'b0;
`endif
        end else begin
            case (state)
                NSA_IDLE: begin
                    if (start) begin
                        a_r      <= a;
                        b_r      <= b;
                        sub_r    <= sub;
                        carry_r  <= sub;
                        cnt      <= '0;
                        result_r <= '0;
`ifdef NSA_OVF_EN
                        msb_r    <= {a[WIDTH-1], b[WIDTH-1]};
`endif
                        state    <= NSA_RUN;
                    end
                end
                NSA_RUN: begin
                    a_r      <= a_r >> NIBBLE_W;
                    b_r      <= b_r >> NIBBLE_W;
                    result_r <= {slice_s, result_r[WIDTH-1:NIBBLE_W]};
                    carry_r  <= slice_cout;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        cout_r <= slice_cout;
`ifdef NSA_OVF_EN
                        ovf_r  <= (msb_r[1] == (msb_r[0] ^ sub_r)) &&
                                  (slice_s[NIBBLE_W-1] != msb_r[1]);
`endif
                        state  <= NSA_DONE;
                    end
                end
                NSA_DONE: begin
                    state <= NSA_IDLE;
                end
                default: begin
                    state <= NSA_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state == NSA_RUN);
    assign done   = (state == NSA_DONE);
    assign result = result_r;
    assign cout   = cout_r;

`ifdef NSA_OVF_EN
    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Testbench for nibble_serial_addsub (WIDTH=16). Honours NSA_OVF_EN when
// predicting the overflow flag.
module tb_nibble_serial_addsub;

    localparam int WIDTH = 16;
`ifdef NSA_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             o;
    } exp_t;

    exp_t sb[$];

    nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .sub    (sub),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: wide integer arithmetic, signed range check for overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s);
        exp_t e;
        logic [WIDTH:0] full;
        int sx;
        int sy;
        int r;
        if (s) full = {1'b0, x} + {1'b0, ~y} + 17'd1;
        else   full = {1'b0, x} + {1'b0, y};
        e.res = full[WIDTH-1:0];
        e.c   = full[WIDTH];
        sx = $signed(x);
        sy = $signed(y);
        r  = s ? (sx - sy) : (sx + sy);
        e.o = OVF_ON && ((r > 32767) || (r < -32768));
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start in the current cycle (cycle 0) and push the expectation.
    task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic s, input exp_t e);
        start = 1'b1;
        a     = x;
        b     = y;
        sub   = s;
        sb.push_back(e);
        tick();
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        sub   = 1'($urandom);
    endtask

    // Wait (bounded) for done, starting in cycle 1; returns the cycle index or -1.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sub   = 1'b0;
        tick();
        tick();
        total++;
        if ({busy, done, result, cout, ovf} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b result=%h cout=%b ovf=%b, want all zero",
                     busy, done, result, cout, ovf);
        end
        rst = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_arith();
        logic [WIDTH-1:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h0007, 16'h7FFF};
        logic [WIDTH-1:0] tb [5] = '{16'h0FCD, 16'h0001, 16'h0007, 16'h0005, 16'h0001};
        logic             ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [WIDTH-1:0] tr [5] = '{16'h2201, 16'h0000, 16'hFFFE, 16'h0002, 16'h8000};
        logic             tc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic             to [5] = '{1'b0, 1'b0, 1'b0, 1'b0, OVF_ON};
        int   lat;
        exp_t e;
        exp_t got;
        for (int i = 0; i < 5; i++) begin
            launch(ta[i], tb[i], ts[i], exp_t'{tr[i], tc[i], to[i]});
            total++;
            if (busy !== 1'b1 || result !== '0) begin
                bad++;
                $display("[TB] FAIL arith_run_start[%0d]: got busy=%b result=%h, want busy=1 result=0000",
                         i, busy, result);
            end
            wait_done(lat);
            e = sb.pop_front();
            total++;
            if (lat !== 5) begin
                bad++;
                $display("[TB] FAIL arith_latency[%0d]: got done in cycle %0d, want 5", i, lat);
            end
            got = '{result, cout, ovf};
            total++;
            if (got !== e) begin
                bad++;
                $display("[TB] FAIL arith_result[%0d]: got result=%h cout=%b ovf=%b, want result=%h cout=%b ovf=%b",
                         i, result, cout, ovf, e.res, e.c, e.o);
            end
            tick();
            got = '{result, cout, ovf};
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || got !== e) begin
                bad++;
                $display("[TB] FAIL arith_hold[%0d]: got done=%b busy=%b result=%h cout=%b ovf=%b, want 0 0 %h %b %b",
                         i, done, busy, result, cout, ovf, e.res, e.c, e.o);
            end
        end
    endtask

    task automatic test_ignore_start();
        int   pulses;
        int   when;
        exp_t e;
        exp_t got;
        launch(16'h1234, 16'h0FCD, 1'b0, exp_t'{16'h2201, 1'b0, 1'b0});
        tick();
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        sub   = 1'b1;
        tick();
        a     = 16'h4321;
        b     = 16'h9999;
        tick();
        start = 1'b0;
        pulses = 0;
        when   = -1;
        e = sb.pop_front();
        for (int k = 4; k <= 16; k++) begin
            if (done) begin
                if (pulses == 0) begin
                    when = k;
                    got  = '{result, cout, ovf};
                    total++;
                    if (got !== e) begin
                        bad++;
                        $display("[TB] FAIL ignore_result: got result=%h cout=%b ovf=%b, want %h %b %b",
                                 result, cout, ovf, e.res, e.c, e.o);
                    end
                end
                pulses++;
            end
            tick();
        end
        total++;
        if (pulses !== 1 || when !== 5) begin
            bad++;
            $display("[TB] FAIL ignore_pulses: got %0d pulses first in cycle %0d, want 1 in cycle 5",
                     pulses, when);
        end
    endtask

    task automatic test_reset_mid_run();
        int   pulses;
        int   lat;
        exp_t e;
        exp_t got;
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h2222;
        sub   = 1'b0;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busy, done, result, cout, ovf} !== '0) begin
            bad++;
            $display("[TB] FAIL midrun_reset: got busy=%b done=%b result=%h cout=%b ovf=%b, want all zero",
                     busy, done, result, cout, ovf);
        end
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) pulses++;
            tick();
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("[TB] FAIL midrun_no_done: got %0d done pulses, want 0", pulses);
        end
        launch(16'h0007, 16'h0005, 1'b1, exp_t'{16'h0002, 1'b1, 1'b0});
        wait_done(lat);
        e = sb.pop_front();
        got = '{result, cout, ovf};
        total++;
        if (lat !== 5 || got !== e) begin
            bad++;
            $display("[TB] FAIL midrun_fresh: got cycle=%0d result=%h cout=%b ovf=%b, want 5 %h %b %b",
                     lat, result, cout, ovf, e.res, e.c, e.o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int               lat;
        exp_t             e;
        exp_t             got;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             s;
        for (int i = 0; i < 8; i++) begin
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            s = 1'($urandom);
            if (i == 0) begin
                x = 16'h8000;
                y = 16'h0001;
                s = 1'b1;
            end
            launch(x, y, s, model(x, y, s));
            wait_done(lat);
            e = sb.pop_front();
            got = '{result, cout, ovf};
            total++;
            if (lat !== 5 || got !== e) begin
                bad++;
                $display("[TB] FAIL b2b[%0d]: a=%h b=%h sub=%b got cycle=%0d result=%h cout=%b ovf=%b, want 5 %h %b %b",
                         i, x, y, s, lat, result, cout, ovf, e.res, e.c, e.o);
            end
            tick();
        end
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty: got %0d entries left, want 0", sb.size());
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sub   = 1'b0;
        test_reset();
        test_arith();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
